gf64_pow_sequencer: RTL and testbench

//  Sequential exponentiation engine for GF(2^6): computes y = x^e for a runtime

---
 rtl/gf64_pow_sequencer_if.sv | 22 ++
 rtl/gf64_pow_sequencer.sv | 120 ++++++++++++
 tb/tb_gf64_pow_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gf64_pow_sequencer_if.sv
// Request/response handshake bundle for the GF(2^6) exponentiation engine.
// The master is the requester/consumer side; the slave is the engine.
interface gf64_pow_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_x;
  logic [5:0] in_e;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_y;
  logic       busy;

  modport master (
    output in_valid, in_x, in_e, out_ready,
    input  in_ready, out_valid, out_y, busy
  );

  modport slave (
    input  in_valid, in_x, in_e, out_ready,
    output in_ready, out_valid, out_y, busy
  );
endinterface

// File: rtl/gf64_pow_sequencer.sv
// GF(2^6) exponentiation engine: y = x^e by left-to-right square-and-multiply,
// sharing one combinational GF(2^6) multiplier between the square and the
// multiply steps. CONST_TIME=1 spends a multiply slot on every exponent bit.
module gf64_pow_sequencer #(
  parameter logic [6:0] POLY       = 7'h43,
  parameter bit         CONST_TIME = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  gf64_pow_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SQR,
    ST_MUL,
    ST_DONE
  } state_t;

  state_t     state_q;
  logic [5:0] acc_q;
  logic [5:0] x_q;
  logic [5:0] e_q;
  logic [2:0] idx_q;
  logic       out_valid_q;
  logic [5:0] out_y_q;

  logic [5:0] op_b;
  logic [5:0] prod;
  logic [5:0] e_shift;
  logic       cur_bit;

  // Carry-less 6x6 product followed by reduction of bits 10..6 modulo POLY.
  // NOTE: blocking assignments here are correct: this is combinational
  // evaluation inside a function, not state that must update on a clock edge.
  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [10:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p = p ^ ({5'b0, a} << i);
    end
    for (int i = 10; i >= 6; i--) begin
      if (p[i]) p = p ^ ({4'b0, POLY} << (i - 6));
    end
    return p[5:0];
  endfunction

  // Shared multiplier: square (acc,acc) in SQR, multiply (acc,x) in MUL.
  // NOTE: every signal written here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    op_b    = (state_q == ST_MUL) ? x_q : acc_q;
    prod    = gf_mul(acc_q, op_b);
    e_shift = e_q >> idx_q;
    cur_bit = e_shift[0];
  end

  // Control FSM with registered result outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= 6'h01;
      x_q         <= '0;
      e_q         <= '0;
      idx_q       <= 3'd5;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_q     <= bus.in_x;
            e_q     <= bus.in_e;
            acc_q   <= 6'h01;
            idx_q   <= 3'd5;
            state_q <= ST_SQR;
          end
        end
        ST_SQR: begin
          acc_q <= prod;
          if (cur_bit || CONST_TIME) begin
            state_q <= ST_MUL;
          end else if (idx_q == 3'd0) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q - 3'd1;
          end
        end
        ST_MUL: begin
          if (cur_bit) acc_q <= prod;
          if (idx_q == 3'd0) begin
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q - 3'd1;
            state_q <= ST_SQR;
          end
        end
        ST_DONE: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
            out_y_q     <= acc_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;

endmodule

// File: tb/tb_gf64_pow_sequencer.sv
// Bench for gf64_pow_sequencer: directed boundary cases, an exhaustive sweep
// with random request noise, DONE back-pressure, mid-operation reset, and a
// constant-time instance checked on random operands.
module tb_gf64_pow_sequencer;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  gf64_pow_sequencer_if bus ();
  gf64_pow_sequencer_if bus_ct ();

  gf64_pow_sequencer #(.POLY(7'h43), .CONST_TIME(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  gf64_pow_sequencer #(.POLY(7'h43), .CONST_TIME(1'b1)) dut_ct (
    .clk (clk),
    .rst (rst),
    .bus (bus_ct.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift-and-add field multiply; power by repeated multiplication.
  function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r;
    logic [5:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_pow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < e; i++) r = ref_mul(r, x);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the CONST_TIME=0 engine. noise drives random in_valid /
  // in_x / in_e while busy; stall holds out_ready low that many cycles in DONE.
  task automatic do_op(input logic [5:0] x, input logic [5:0] e, input int stall,
                       input bit noise, output logic [5:0] y, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_request", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_e     = e;
    @(posedge clk);
    #1;
    check("busy_after_accept", bus.busy, 1);
    lat = 0;
    do begin
      @(negedge clk);
      if (noise) begin
        bus.in_valid = 1'($urandom);
        bus.in_x     = 6'($urandom);
        bus.in_e     = 6'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (!bus.out_valid) check("out_y_zero_while_invalid", bus.out_y, 0);
    end while (!bus.out_valid && lat < 40);
    y = bus.out_y;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      bus.in_valid = noise ? 1'($urandom) : 1'b0;
      bus.in_x     = 6'($urandom);
      bus.in_e     = 6'($urandom);
      @(posedge clk);
      #1;
      check("stall_out_valid_held", bus.out_valid, 1);
      check("stall_out_y_stable", bus.out_y, y);
      check("stall_in_ready_low", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop_after_handshake", bus.out_valid, 0);
    check("out_y_zero_after_handshake", bus.out_y, 0);
    check("idle_after_handshake", bus.in_ready, 1);
  endtask

  task automatic run_check(input logic [5:0] x, input logic [5:0] e,
                           input int stall, input bit noise);
    logic [5:0] y;
    int         lat;
    do_op(x, e, stall, noise, y, lat);
    check($sformatf("y x=%0h e=%0d", x, e), y, ref_pow(x, int'(e)));
    check($sformatf("lat e=%0d", e), lat, 7 + $countones(e));
  endtask

  // One transaction on the CONST_TIME=1 engine; out_ready held high there.
  task automatic run_ct(input logic [5:0] x, input logic [5:0] e);
    int guard;
    int lat;
    guard = 0;
    @(negedge clk);
    while (!bus_ct.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus_ct.in_valid = 1'b1;
    bus_ct.in_x     = x;
    bus_ct.in_e     = e;
    @(posedge clk);
    @(negedge clk);
    bus_ct.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus_ct.out_valid && lat < 40);
    check($sformatf("ct_y x=%0h e=%0d", x, e), bus_ct.out_y, ref_pow(x, int'(e)));
    check("ct_latency", lat, 13);
    @(posedge clk);
    #1;
    check("ct_out_valid_drop", bus_ct.out_valid, 0);
  endtask

  initial begin
    logic [5:0] y;
    int         lat;
    bit         seen_valid;

    tests_run       = 0;
    tests_failed    = 0;
    bus.in_valid    = 1'b0;
    bus.in_x        = '0;
    bus.in_e        = '0;
    bus.out_ready   = 1'b0;
    bus_ct.in_valid = 1'b0;
    bus_ct.in_x     = '0;
    bus_ct.in_e     = '0;
    bus_ct.out_ready = 1'b1;
    rst = 1'b1;
    #23;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_y", bus.out_y, 0);
    check("reset_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1);

    // Directed cases with independent constants.
    do_op(6'h02, 6'd1, 0, 1'b0, y, lat);
    check("x2_e1_y", y, 6'h02);
    check("x2_e1_latency", lat, 8);
    do_op(6'h02, 6'd6, 0, 1'b0, y, lat);
    check("x2_e6_y", y, 6'h03);
    do_op(6'h02, 6'd62, 0, 1'b0, y, lat);
    check("x2_inverse", y, 6'h21);
    do_op(6'h00, 6'd0, 0, 1'b0, y, lat);
    check("zero_pow_zero", y, 6'h01);
    check("e0_latency", lat, 7);
    do_op(6'h00, 6'd5, 0, 1'b0, y, lat);
    check("zero_pow_5", y, 6'h00);
    do_op(6'h2B, 6'd63, 0, 1'b0, y, lat);
    check("x2b_pow_63", y, 6'h01);
    check("e63_latency", lat, 13);
    do_op(6'h00, 6'd62, 0, 1'b0, y, lat);
    check("zero_inverse", y, 6'h00);

    // DONE back-pressure with request pulses that must be ignored.
    run_check(6'h17, 6'd45, 5, 1'b1);
    check("idle_after_stall", bus.busy, 0);

    // Exhaustive sweep, random noise on the request side.
    for (int x = 0; x < 64; x++) begin
      for (int e = 0; e < 64; e++) begin
        run_check(6'(x), 6'(e), 0, ($urandom_range(3) == 0));
      end
    end

    // Random operands with random back-pressure.
    for (int i = 0; i < 40; i++) begin
      run_check(6'($urandom), 6'($urandom), $urandom_range(3), 1'b1);
    end

    // Constant-time engine.
    run_ct(6'h02, 6'd1);
    run_ct(6'h00, 6'd0);
    for (int i = 0; i < 60; i++) begin
      run_ct(6'($urandom), 6'($urandom));
    end

    // Reset while the engine is in MUL for e=0x3F.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 6'h15;
    bus.in_e     = 6'h3F;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midop_rst_out_valid", bus.out_valid, 0);
    check("midop_rst_out_y", bus.out_y, 0);
    check("midop_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midop_release_in_ready", bus.in_ready, 1);
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("midop_no_out_valid_pulse", seen_valid, 0);
    do_op(6'h02, 6'd1, 0, 1'b0, y, lat);
    check("after_abort_y", y, 6'h02);
    check("after_abort_latency", lat, 8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
